// File: rtl/imm_encoder_pkg.sv
// Shared types and helpers for the immediate encoder: immediate classes, FSM states,
// and the rotate-left used by the data-processing search.
package imm_encoder_pkg;

  typedef enum logic [1:0] {
    IMM_DP  = 2'b00,
    IMM_MEM = 2'b01,
    IMM_BR  = 2'b10,
    IMM_RSV = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_e;

  localparam logic [3:0] MAX_ROT = 4'd15;

  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] sh);
    logic [63:0] t;
    t = {v, v} << sh;
    return t[63:32];
  endfunction

endpackage

// File: rtl/imm_rot_check.sv
// Tests one rotation of the data-processing search: undoing the rotation must leave
// only the low eight bits populated for the value to be encodable at this rot.
module imm_rot_check
  import imm_encoder_pkg::*;
(
  input  logic [31:0] Value,
  input  logic [3:0]  rot,
  output logic [7:0]  imm8,
  output logic        match
);

  logic [31:0] w_rotated;

  assign w_rotated = rol32(Value, {rot, 1'b0});
  assign imm8      = w_rotated[7:0];
  assign match     = (w_rotated[31:8] == 24'd0);

endmodule

// File: rtl/imm_encoder.sv
// Multi-cycle immediate encoder: finds the 24-bit instruction field that the extension
// path expands back to Value, or reports that no such field exists.
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] Value,
  input  logic [1:0]  ImmSrc,
  output logic [23:0] Imm24,
  output logic        ok,
  output logic        done,
  output logic        busy
);

  state_e      r_state, w_state_next;
  logic [3:0]  r_rot, w_rot_next;
  logic [31:0] r_value, w_value_next;
  logic [23:0] r_imm24, w_imm24_next;
  logic        r_ok, w_ok_next;

  logic [7:0]  w_imm8;
  logic        w_match;
  logic        w_mem_ok;
  logic        w_br_ok;

  imm_rot_check u_rot_check (
    .Value (r_value),
    .rot   (r_rot),
    .imm8  (w_imm8),
    .match (w_match)
  );

  // MEM/BR are judged straight from the inputs in the accepting cycle.
  assign w_mem_ok = (Value[31:12] == 20'd0);
  assign w_br_ok  = (Value[1:0] == 2'b00) &&
                    ((Value[31:25] == 7'h00) || (Value[31:25] == 7'h7f));

  always_comb begin
    w_state_next = r_state;
    w_rot_next   = r_rot;
    w_value_next = r_value;
    w_imm24_next = r_imm24;
    w_ok_next    = r_ok;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_value_next = Value;
          w_rot_next   = 4'd0;
          unique case (imm_src_e'(ImmSrc))
            IMM_DP: w_state_next = SEARCH;
            IMM_MEM: begin
              w_ok_next    = w_mem_ok;
              w_imm24_next = w_mem_ok ? {12'd0, Value[11:0]} : 24'd0;
              w_state_next = DONE;
            end
            IMM_BR: begin
              w_ok_next    = w_br_ok;
              w_imm24_next = w_br_ok ? Value[25:2] : 24'd0;
              w_state_next = DONE;
            end
            default: begin
              w_ok_next    = 1'b0;
              w_imm24_next = 24'd0;
              w_state_next = DONE;
            end
          endcase
        end
      end
      SEARCH: begin
        if (w_match) begin
          w_imm24_next = {12'd0, r_rot, w_imm8};
          w_ok_next    = 1'b1;
          w_state_next = DONE;
        end else if (r_rot == MAX_ROT) begin
          w_imm24_next = 24'd0;
          w_ok_next    = 1'b0;
          w_state_next = DONE;
        end else begin
          w_rot_next = r_rot + 4'd1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rot   <= 4'd0;
      r_value <= 32'd0;
      r_imm24 <= 24'd0;
      r_ok    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rot   <= w_rot_next;
      r_value <= w_value_next;
      r_imm24 <= w_imm24_next;
      r_ok    <= w_ok_next;
    end
  end

  assign Imm24 = r_imm24;
  assign ok    = r_ok;
  assign done  = (r_state == DONE);
  assign busy  = (r_state == SEARCH);

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors with hand-computed results plus
// random round trips through an independent model of the immediate-extension path.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] Value = 32'd0;
  logic [1:0]  ImmSrc = 2'b00;
  logic [23:0] Imm24;
  logic        ok;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] val;
    bit          exact;
    logic [23:0] eimm;
    bit          eok;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];

  imm_encoder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .Value  (Value),
    .ImmSrc (ImmSrc),
    .Imm24  (Imm24),
    .ok     (ok),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] extend(input logic [23:0] imm, input logic [1:0] src);
    logic [63:0] t;
    case (src)
      2'b00: begin
        t = {32'd0, 24'd0, imm[7:0], 24'd0, imm[7:0]} >> {imm[11:8], 1'b0};
        return t[31:0];
      end
      2'b01:   return {20'd0, imm[11:0]};
      2'b10:   return {{6{imm[23]}}, imm, 2'b00};
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  // Monitor: pops the oldest expectation whenever the DUT signals completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion (Imm24=%h)", Imm24);
      end else begin
        e = sb.pop_front();
        check({e.name, " busy_in_done"}, {31'd0, busy}, 32'd0);
        if (e.exact) begin
          check({e.name, " ok"}, {31'd0, ok}, {31'd0, e.eok});
          check({e.name, " imm24"}, {8'd0, Imm24}, {8'd0, e.eimm});
        end else begin
          check({e.name, " rt_ok"}, {31'd0, ok}, 32'd1);
          check({e.name, " rt_value"}, extend(Imm24, e.src), e.val);
        end
        if (e.lat >= 0) check({e.name, " latency"}, cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input logic [1:0] src, input logic [31:0] val, input bit push,
                       input bit exact, input logic [23:0] eimm, input bit eok,
                       input int lat, input string nm);
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s idle_wait: got busy=%b expected idle within 100 cycles", nm, busy);
    end
    ImmSrc = src;
    Value  = val;
    start  = 1'b1;
    if (push) sb.push_back('{src, val, exact, eimm, eok, lat, cyc, nm});
    @(negedge clk);
    start  = 1'b0;
    Value  = $urandom;
    ImmSrc = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  r8;
    logic [3:0]  rr;
    logic [23:0] r24;
    logic [63:0] t;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset ok", {31'd0, ok}, 32'd0);
    check("reset imm24", {8'd0, Imm24}, 32'd0);
    rst_n = 1'b1;

    issue(2'b00, 32'd200,        1, 1, 24'h0000C8, 1, 2,  "dp_200");
    issue(2'b00, 32'h0000_0000,  1, 1, 24'h000000, 1, 2,  "dp_zero");
    issue(2'b00, 32'h0000_0101,  1, 1, 24'h000000, 0, 17, "dp_nomatch");
    issue(2'b00, 32'h0000_03FC,  1, 1, 24'h000FFF, 1, 17, "dp_rot15");
    issue(2'b01, 32'd134,        1, 1, 24'h000086, 1, 1,  "mem_134");
    issue(2'b01, 32'd4096,       1, 1, 24'h000000, 0, 1,  "mem_4096");
    issue(2'b01, 32'd4095,       1, 1, 24'h000FFF, 1, 1,  "mem_4095");
    issue(2'b10, 32'hFFFF_FFF8,  1, 1, 24'hFFFFFE, 1, 1,  "br_neg8");
    issue(2'b10, 32'd6,          1, 1, 24'h000000, 0, 1,  "br_6");
    issue(2'b10, 32'h0200_0000,  1, 1, 24'h000000, 0, 1,  "br_2000000");
    issue(2'b10, 32'h01FF_FFFC,  1, 1, 24'h7FFFFF, 1, 1,  "br_maxpos");
    issue(2'b11, 32'd4,          1, 1, 24'h000000, 0, 1,  "rsv");
    drain();

    // Start during a search must be ignored.
    issue(2'b00, 32'hFF00_0000, 1, 1, 24'h0004FF, 1, 6, "dp_ff000000");
    @(negedge clk);
    @(negedge clk);
    check("busy_cycle3", {31'd0, busy}, 32'd1);
    ImmSrc = 2'b01;
    Value  = 32'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    check("ignored_start_imm24", {8'd0, Imm24}, 32'h0004FF);

    // Reset in cycle 3 of a search aborts it without a done pulse.
    issue(2'b00, 32'hFF00_0000, 0, 1, 24'h0, 0, -1, "dp_abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort imm24", {8'd0, Imm24}, 32'd0);
    check("abort ok", {31'd0, ok}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(2'b00, 32'd200, 1, 1, 24'h0000C8, 1, 2, "after_reset");
    drain();

    for (int i = 0; i < 200; i++) begin
      r8 = 8'($urandom);
      rr = 4'($urandom);
      t  = {24'd0, r8, 24'd0, r8} >> {rr, 1'b0};
      issue(2'b00, t[31:0], 1, 0, 24'h0, 1, -1, "rt_dp");
      issue(2'b01, 32'($urandom_range(0, 4095)), 1, 0, 24'h0, 1, 1, "rt_mem");
      r24 = 24'($urandom);
      issue(2'b10, {{6{r24[23]}}, r24, 2'b00}, 1, 0, 24'h0, 1, 1, "rt_br");
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Multi-cycle immediate encoder: the inverse of the processor's immediate-extension path. Given a 32-bit target value and an immediate class, it searches for or checks a legal instruction immediate field. It returns the 24-bit field that the extension logic expands back to the same value, and flags values that cannot be encoded. It sits beside the single-cycle core, serving the boot/program loader and self-check logic, which build instruction words at run time.

## Interface
Parameters:
- none; all widths are fixed by the ISA (32-bit data, 24-bit immediate field).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only while busy=0
- Value  in  32  target value that the extended immediate must equal; captured on an accepted start
- ImmSrc  in  2  immediate class: 00 data-processing rotated imm8, 01 LDR/STR 12-bit offset, 10 branch 24-bit word offset, 11 reserved
- Imm24  out  24  encoded instruction bits [23:0]; registered; held until the next done
- ok  out  1  value is encodable; valid when done=1 and held afterwards
- done  out  1  single-cycle completion pulse
- busy  out  1  request in progress; high from the cycle after an accepted start until the cycle done is asserted

## Operation
- States:
  - IDLE: start=1 captures Value and ImmSrc.
    - DP: go to SEARCH with rot=0.
    - MEM, BR, reserved: result is computed from the captured inputs; go to DONE.
  - SEARCH (DP only): test the current rot, with imm8 = rol(Value, 2*rot)[7:0].
    - Match means rol(Value, 2*rot)[31:8] == 0.
    - On match: latch Imm24 = {12'b0, rot[3:0], imm8}, set ok=1, go to DONE.
    - Else if rot==15: set Imm24=0, ok=0, go to DONE.
    - Else: rot increments.
  - DONE: done=1 for one cycle, then IDLE.
- Rotation selection: the smallest matching rot wins. Value=0 gives rot=0, imm8=0.
- MEM: ok = (Value[31:12]==0); Imm24 = {12'b0, Value[11:0]} when ok.
- BR: ok = (Value[1:0]==0) and Value[31:25] all equal Value[25], i.e. a signed 26-bit byte offset. Imm24 = Value[25:2] when ok.
- Reserved ImmSrc: ok=0.
- Whenever ok=0: Imm24 = 0.
- Round-trip invariant: when ok=1, feeding Imm24 and ImmSrc into the extension logic yields exactly Value.
- start while busy=1: ignored; no queuing.
- Value and ImmSrc changing after capture: no effect.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- MEM/BR/reserved: done=1 in cycle 1.
- DP, match at rotation k: done=1 in cycle k+2. DP with no match: done=1 in cycle 17.
- Imm24 and ok update on the same edge that raises done. They are stable from the done cycle until the next done.
- busy=1 from cycle 1 up to and including the cycle before done; busy=0 in the done cycle.
- A new start in the done cycle is ignored. The earliest new accept is the cycle after done.
- Reset values (asynchronous on rst_n=0): state=IDLE, rot=0, Imm24=0, ok=0, done=0, busy=0.
- Reset mid-SEARCH aborts the request with no done pulse. After rst_n rises, the first start is accepted normally.

## Structure
- Package imm_encoder_pkg holds:
  - ImmSrc enum: IMM_DP=2'b00, IMM_MEM=2'b01, IMM_BR=2'b10, IMM_RSV=2'b11.
  - FSM state enum: IDLE, SEARCH, DONE.
  - Constant MAX_ROT=4'd15.
- One combinational sub-module, imm_rot_check: inputs Value[31:0] and rot[3:0]; outputs imm8[7:0] and match. It is instantiated once and driven by the rot counter.
- The top level holds the FSM, rot counter, capture registers and the MEM/BR checks.

## Test plan
- DP Value=200 -> done in cycle 2, ok=1, Imm24=24'h0000C8.
- DP Value=32'hFF000000 -> done in cycle 6, ok=1, Imm24=24'h0004FF (rot=4). Also DP Value=32'h00000101 -> done in cycle 17, ok=0, Imm24=0.
- MEM Value=134 -> done in cycle 1, ok=1, Imm24=24'h000086. Also MEM Value=4096 -> ok=0, Imm24=0.
- BR Value=32'hFFFFFFF8 -> ok=1, Imm24=24'hFFFFFE. BR Value=6 -> ok=0. BR Value=32'h02000000 -> ok=0. ImmSrc=11 -> ok=0.
- Start pulsed in cycle 3 of a DP search -> ignored; the original result is unchanged. Separately, rst_n=0 in cycle 3 of a search -> busy=0, done=0, Imm24=0 immediately, and no done pulse follows.
- Round trip: run 200 random encodable values per class. Pass each Imm24/ImmSrc through the extension logic and require the result to equal Value.
